// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding, hazard detection and long-latency register scoreboard for the
// 5-stage core. Produces EX operand forward selects, IF/ID stall and flush
// controls, tracks registers awaiting a mul/div writeback, and counts stall
// cycles with a saturating counter.
module fwd_hazard_scoreboard #(
  parameter int NUM_SRC     = 2,
  parameter int ADDR_W      = 5,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 16,
  localparam int NREG       = 2 ** ADDR_W,
  localparam int PW         = $clog2(MAX_PENDING + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*ADDR_W-1:0] rs_d,
  input  logic [ADDR_W-1:0]         rd_d,
  input  logic                      reg_write_d,
  input  logic                      lat_d,
  input  logic [NUM_SRC*ADDR_W-1:0] rs_e,
  input  logic [ADDR_W-1:0]         rd_e,
  input  logic                      mem_read_e,
  input  logic                      pc_src_e,
  input  logic                      lat_issue,
  input  logic [ADDR_W-1:0]         lat_issue_rd,
  input  logic                      lat_done,
  input  logic [ADDR_W-1:0]         lat_done_rd,
  input  logic [ADDR_W-1:0]         rd_m,
  input  logic [ADDR_W-1:0]         rd_w,
  input  logic                      reg_write_m,
  input  logic                      reg_write_w,
  output logic [2*NUM_SRC-1:0]      forward_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic [NREG-1:0]           busy,
  output logic [PW-1:0]             pending_cnt,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic            lu;
  logic            sb;
  logic            hz;
  logic            set_v;
  logic            clr_v;
  logic [NREG-1:0] busy_nxt;
  logic [PW-1:0]   pend_nxt;

  // Per-operand EX forward select; MEM beats WB, x0 never forwarded.
  always_comb begin
    forward_e = '0;
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (reg_write_m && (rd_m != '0) && (rd_m == rs_e[i*ADDR_W +: ADDR_W]))
          forward_e[2*i +: 2] = 2'b10;
        else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e[i*ADDR_W +: ADDR_W]))
          forward_e[2*i +: 2] = 2'b01;
      end
    end
  end

  // Load-use and scoreboard (RAW, WAW, capacity) hazard detection.
  always_comb begin
    lu = 1'b0;
    sb = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mem_read_e && (rd_e != '0) && (rs_d[i*ADDR_W +: ADDR_W] == rd_e))
        lu = 1'b1;
      if (busy[rs_d[i*ADDR_W +: ADDR_W]])
        sb = 1'b1;
    end
    if (reg_write_d && (rd_d != '0) && busy[rd_d])
      sb = 1'b1;
    if (lat_d && (pending_cnt == PEND_MAX))
      sb = 1'b1;
  end

  // Stall/flush steering; a taken branch overrides any hazard.
  always_comb begin
    hz      = lu | sb;
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (!rst) begin
      if (pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        stall_f = hz;
        stall_d = hz;
        flush_e = hz;
      end
    end
  end

  // Next scoreboard state: set wins over a same-register clear.
  always_comb begin
    set_v    = lat_issue && (lat_issue_rd != '0);
    clr_v    = lat_done && busy[lat_done_rd];
    busy_nxt = busy;
    pend_nxt = pending_cnt;
    if (clr_v)
      busy_nxt[lat_done_rd] = 1'b0;
    if (set_v)
      busy_nxt[lat_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
    if (set_v && !clr_v && (pending_cnt < PEND_MAX))
      pend_nxt = pending_cnt + PW'(1);
    else if (clr_v && !set_v && (pending_cnt != '0))
      pend_nxt = pending_cnt - PW'(1);
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_nxt;
      pending_cnt <= pend_nxt;
    end
  end

  // Saturating count of decode-stall cycles.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall_d)
      stall_cnt <= sat_inc(stall_cnt);
  end

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
Parametrised successor to the pipeline's two-operand EX forwarding logic. It covers NUM_SRC operands, MEM/WB forwarding, load-use stall/bubble generation, branch flush, and a register scoreboard for long-latency (mul/div) writebacks. It sits between the decode, execute, memory and writeback stages of the 5-stage RISC-V core and drives all stall, flush and forward controls.

Parameters:
NUM_SRC, 2, number of source operands checked per instruction (2 or 3)
ADDR_W, 5, register address width; register file holds 2**ADDR_W entries, index 0 hardwired zero
MAX_PENDING, 4, maximum simultaneously outstanding long-latency writes
CNT_W, 16, stall performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
rs_d  in  NUM_SRC*ADDR_W  decode-stage sources, operand i at [i*ADDR_W +: ADDR_W]
rd_d  in  ADDR_W  decode-stage destination
reg_write_d  in  1  decode instruction writes rd_d
lat_d  in  1  decode instruction is long-latency
rs_e  in  NUM_SRC*ADDR_W  execute-stage sources, same packing as rs_d
rd_e  in  ADDR_W  execute-stage destination
mem_read_e  in  1  execute instruction is a load
pc_src_e  in  1  branch/jump taken in EX
lat_issue  in  1  long-latency op leaves EX into the functional unit this cycle
lat_issue_rd  in  ADDR_W  its destination
lat_done  in  1  long-latency result written back this cycle
lat_done_rd  in  ADDR_W  its destination
rd_m, rd_w  in  ADDR_W  MEM/WB destinations
reg_write_m, reg_write_w  in  1  MEM/WB write enables
forward_e  out  2*NUM_SRC  per-operand select at [2i +: 2]: 00 regfile, 10 MEM, 01 WB
stall_f, stall_d  out  1  hold PC / IF-ID register
flush_d, flush_e  out  1  clear IF-ID / insert bubble into ID-EX
busy  out  2**ADDR_W  scoreboard busy bits
pending_cnt  out  clog2(MAX_PENDING+1)  outstanding long-latency writes
stall_cnt  out  CNT_W  saturating count of stall_d cycles

Behaviour:
- Reset, sync on clk while rst=1: busy=0, pending_cnt=0, stall_cnt=0. While rst is high, all combinational outputs (forward_e, stall_*, flush_*) are forced to 0.
- Forwarding is combinational, per operand i:
  - 10 if reg_write_m && rd_m!=0 && rd_m==rs_e[i]
  - else 01 if reg_write_w && rd_w!=0 && rd_w==rs_e[i]
  - else 00
  - MEM has strict priority over WB. x0 is never forwarded.
- Load-use hazard (lu) is combinational: mem_read_e && rd_e!=0 && any i with rs_d[i]==rd_e.
- Scoreboard hazard (sb), combinational:
  - any i with busy[rs_d[i]] (RAW), or
  - reg_write_d && rd_d!=0 && busy[rd_d] (WAW), or
  - lat_d && pending_cnt==MAX_PENDING (capacity).
- Stall/flush:
  - hz = lu|sb
  - pc_src_e=1: flush_d=1, flush_e=1, stall_f=stall_d=0. Branch overrides any hazard.
  - otherwise: stall_f=stall_d=flush_e=hz, flush_d=0.
- Scoreboard update on each clk edge (rst=0):
  - set busy[lat_issue_rd] when lat_issue && lat_issue_rd!=0
  - clear busy[lat_done_rd] when lat_done && busy[lat_done_rd]
  - same register set and cleared in the same cycle: set wins (busy stays 1)
  - completion of a non-busy register or of x0 is ignored
  - busy[0] is always 0
- pending_cnt:
  - +1 on a valid set, -1 on a valid clear, unchanged when both occur
  - never wraps: an issue at MAX_PENDING is a protocol error and does not increment
  - a clear at 0 cannot occur (no busy bits set)
- stall_cnt: +1 each cycle stall_d=1; saturates at all-ones.
- Latency: hazard outputs are combinational in the same cycle. busy/pending_cnt reflect an issue/done one cycle after the edge it is sampled on.
- Reset mid-operation: every outstanding busy bit is dropped. The pipeline is flushed externally on reset.

Test Plan:
1. Forward priority: reg_write_m=reg_write_w=1, rd_m=rd_w=rs_e[0]=5, rs_e[1]=7, rd_w=7 elsewhere n/a → forward_e[1:0]=10. Then rd_m=6 → forward_e[1:0]=01. Then rd_m=rd_w=0, rs_e=0 → 00.
2. Load-use: mem_read_e=1, rd_e=3, rs_d[1]=3 → stall_f=stall_d=flush_e=1, flush_d=0. Add pc_src_e=1 in the same cycle → stall_f=stall_d=0, flush_d=flush_e=1.
3. Scoreboard RAW: lat_issue=1, lat_issue_rd=9 → next cycle busy[9]=1, pending_cnt=1. Then rs_d[0]=9 → stall_d=1 every cycle until lat_done=1, lat_done_rd=9; one cycle later busy[9]=0, stall_d=0. stall_cnt equals the number of stalled cycles.
4. Capacity: MAX_PENDING=4, issue rd 1..4 → pending_cnt=4. Then lat_d=1 with no RAW → stall_d=1. lat_done_rd=2 → pending_cnt=3, stall_d drops.
5. Same-cycle issue and done on rd=8 with busy[8]=1 → busy[8] stays 1, pending_cnt unchanged. Done on non-busy rd=12 → no change. Issue rd=0 → busy[0]=0, pending_cnt unchanged.
6. Reset and saturation: assert rst with busy nonzero → next cycle busy=0, pending_cnt=0, stall_cnt=0. With CNT_W=4, hold stall_d for 20 cycles → stall_cnt=15.
